// File: rtl/vital_threshold_monitor_pkg.sv
// Shared types and constants for the vital-sign threshold monitor.
// Holds the FSM state encoding and the lt/eq/gt cascade used by the serial comparators.
package vitals_pkg;

   localparam int SLICE_W = 3;

   typedef enum logic [1:0] {
      IDLE,
      CMP,
      DONE
   } stateT;

   typedef struct packed {
      logic lt;
      logic eq;
      logic gt;
   } cascadeT;

   localparam cascadeT CASCADE_EQ = '{lt: 1'b0, eq: 1'b1, gt: 1'b0};

endpackage

// File: rtl/vital_threshold_monitor_if.sv
// Sample handshake, threshold inputs, result flags and alarm control for one channel.
// The sampler/alarm side uses master; the monitor itself uses slave.
interface vital_threshold_monitor_if #(
   parameter int WIDTH = 9
);

   logic             sample_valid;
   logic             sample_ready;
   logic [WIDTH-1:0] sample;
   logic [WIDTH-1:0] low_thr;
   logic [WIDTH-1:0] high_thr;
   logic             result_valid;
   logic             below;
   logic             above;
   logic             in_range;
   logic             alarm;
   logic             alarm_clear;

   modport master (
      output sample_valid, sample, low_thr, high_thr, alarm_clear,
      input  sample_ready, result_valid, below, above, in_range, alarm
   );

   modport slave (
      input  sample_valid, sample, low_thr, high_thr, alarm_clear,
      output sample_ready, result_valid, below, above, in_range, alarm
   );

endinterface

// File: rtl/vital_threshold_monitor_cmp_slice3.sv
// One 3-bit step of an MSB-first magnitude comparison.
// Once a higher slice has decided (eq=0), that decision passes through unchanged.
module cmp_slice3
   import vitals_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  cascadeT            cascIn,
   output cascadeT            cascOut
);

   always_comb begin
      cascOut = cascIn;
      if (cascIn.eq) begin
         cascOut.lt = (a < b);
         cascOut.eq = (a == b);
         cascOut.gt = (a > b);
      end
   end

endmodule

// File: rtl/vital_threshold_monitor.sv
// Serial low/high threshold checker with registered range flags and a sticky, debounced alarm.
// Operands shift left one slice per CMP cycle, so the active slice is always the top 3 bits.
module vital_threshold_monitor
   import vitals_pkg::*;
#(
   parameter int WIDTH    = 9,
   parameter int DEBOUNCE = 3
) (
   input logic                      clk,
   input logic                      rst_n,
   vital_threshold_monitor_if.slave bus
);

   localparam int               S        = WIDTH / SLICE_W;
   localparam int               IDX_W    = (S > 1) ? $clog2(S) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(S - 1);
   localparam logic [3:0]       DEB_MAX  = 4'(DEBOUNCE);

   stateT            state;
   stateT            nextState;
   logic [WIDTH-1:0] sampleSh;
   logic [WIDTH-1:0] lowSh;
   logic [WIDTH-1:0] highSh;
   logic [IDX_W-1:0] sliceIdx;
   cascadeT          lowCasc;
   cascadeT          highCasc;
   cascadeT          lowNext;
   cascadeT          highNext;
   logic             belowReg;
   logic             aboveReg;
   logic             inRangeReg;
   logic             alarmReg;
   logic [3:0]       count;
   logic             accept;
   logic             lastSlice;
   logic             outOfRange;

   assign accept     = (state == IDLE) && bus.sample_valid;
   assign lastSlice  = (sliceIdx == '0);
   assign outOfRange = belowReg || aboveReg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (bus.sample_valid) nextState = CMP;
         CMP:     if (lastSlice) nextState = DONE;
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   cmp_slice3 lowCmp (
      .a       (sampleSh[WIDTH-1 -: SLICE_W]),
      .b       (lowSh[WIDTH-1 -: SLICE_W]),
      .cascIn  (lowCasc),
      .cascOut (lowNext)
   );

   cmp_slice3 highCmp (
      .a       (sampleSh[WIDTH-1 -: SLICE_W]),
      .b       (highSh[WIDTH-1 -: SLICE_W]),
      .cascIn  (highCasc),
      .cascOut (highNext)
   );

   // Flags are loaded on the final CMP edge so they are already stable during DONE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sampleSh   <= '0;
         lowSh      <= '0;
         highSh     <= '0;
         sliceIdx   <= '0;
         lowCasc    <= CASCADE_EQ;
         highCasc   <= CASCADE_EQ;
         belowReg   <= 1'b0;
         aboveReg   <= 1'b0;
         inRangeReg <= 1'b0;
      end else if (accept) begin
         sampleSh <= bus.sample;
         lowSh    <= bus.low_thr;
         highSh   <= bus.high_thr;
         sliceIdx <= LAST_IDX;
         lowCasc  <= CASCADE_EQ;
         highCasc <= CASCADE_EQ;
      end else if (state == CMP) begin
         sampleSh <= sampleSh << SLICE_W;
         lowSh    <= lowSh << SLICE_W;
         highSh   <= highSh << SLICE_W;
         sliceIdx <= sliceIdx - IDX_W'(1);
         lowCasc  <= lowNext;
         highCasc <= highNext;
         if (lastSlice) begin
            belowReg   <= lowNext.lt;
            aboveReg   <= highNext.gt;
            inRangeReg <= !lowNext.lt && !highNext.gt;
         end
      end
   end

   // A clear still counts the result retiring on the same edge, so the count restarts at 1.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count    <= 4'd0;
         alarmReg <= 1'b0;
      end else if (bus.alarm_clear) begin
         alarmReg <= 1'b0;
         count    <= ((state == DONE) && outOfRange) ? 4'd1 : 4'd0;
      end else if (state == DONE) begin
         if (outOfRange) begin
            if (count < DEB_MAX) count <= count + 4'd1;
            if (count >= DEB_MAX - 4'd1) alarmReg <= 1'b1;
         end else begin
            count <= 4'd0;
         end
      end
   end

   assign bus.sample_ready = (state == IDLE);
   assign bus.result_valid = (state == DONE);
   assign bus.below        = belowReg;
   assign bus.above        = aboveReg;
   assign bus.in_range     = inRangeReg;
   assign bus.alarm        = alarmReg;

endmodule

// File: tb/tb_vital_threshold_monitor.sv
// Directed bench for vital_threshold_monitor with WIDTH=9, DEBOUNCE=3, limits 60..100.
// Each scenario task drives its own samples and checks against hand-computed values.
module tb_vital_threshold_monitor;

   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   vital_threshold_monitor_if #(.WIDTH(9)) bus ();

   vital_threshold_monitor #(.WIDTH(9), .DEBOUNCE(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Accept one sample, wait (bounded) for result_valid, then step through the DONE->IDLE edge.
   task automatic driveSample(input logic [8:0] s, input logic clearAtDone, output int lat,
                              output logic gBelow, output logic gAbove, output logic gInRange,
                              output logic gAlarmAtResult, output logic gAlarmAfter,
                              output logic gReadyAfter, output logic gHighEqAfter1);
      lat = -1;
      gBelow = 1'b0; gAbove = 1'b0; gInRange = 1'b0;
      gAlarmAtResult = 1'b0; gHighEqAfter1 = 1'b1;
      bus.sample       = s;
      bus.sample_valid = 1'b1;
      @(posedge clk); #1;
      bus.sample_valid = 1'b0;
      for (int i = 1; i <= 10 && lat < 0; i++) begin
         @(posedge clk); #1;
         if (i == 1) gHighEqAfter1 = dut.highCasc.eq;
         if (bus.result_valid) begin
            lat            = i;
            gBelow         = bus.below;
            gAbove         = bus.above;
            gInRange       = bus.in_range;
            gAlarmAtResult = bus.alarm;
         end
      end
      if (clearAtDone) bus.alarm_clear = 1'b1;
      @(posedge clk); #1;
      bus.alarm_clear = 1'b0;
      gAlarmAfter = bus.alarm;
      gReadyAfter = bus.sample_ready;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({bus.sample_ready, bus.result_valid, bus.below, bus.above, bus.in_range, bus.alarm} !== 6'b100000) begin
         bad++;
         $display("[TB] FAIL reset_state: got %b want 100000",
                  {bus.sample_ready, bus.result_valid, bus.below, bus.above, bus.in_range, bus.alarm});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int lat;
      logic b, a, r, alR, alA, rdy, heq;
      driveSample(9'd80, 1'b0, lat, b, a, r, alR, alA, rdy, heq);
      total++;
      if (lat !== 3) begin
         bad++; $display("[TB] FAIL basic_latency: got %0d want 3", lat);
      end
      total++;
      if ({b, a, r} !== 3'b001) begin
         bad++; $display("[TB] FAIL basic_flags: got below/above/in_range=%b want 001", {b, a, r});
      end
      total++;
      if (rdy !== 1'b1) begin
         bad++; $display("[TB] FAIL basic_ready_after: got %b want 1", rdy);
      end
   endtask

   task automatic test_boundaries();
      logic [8:0] vals [5] = '{9'd60, 9'd100, 9'd59, 9'd101, 9'd80};
      logic [2:0] expF [5] = '{3'b001, 3'b001, 3'b100, 3'b010, 3'b001};
      int lat;
      logic b, a, r, alR, alA, rdy, heq;
      for (int k = 0; k < 5; k++) begin
         driveSample(vals[k], 1'b0, lat, b, a, r, alR, alA, rdy, heq);
         total++;
         if (lat !== 3 || {b, a, r} !== expF[k]) begin
            bad++;
            $display("[TB] FAIL boundary_%0d: got lat=%0d flags=%b want lat=3 flags=%b",
                     vals[k], lat, {b, a, r}, expF[k]);
         end
         total++;
         if (alA !== 1'b0) begin
            bad++; $display("[TB] FAIL boundary_alarm_%0d: got %b want 0", vals[k], alA);
         end
      end
   endtask

   task automatic test_extremes();
      int lat;
      logic b, a, r, alR, alA, rdy, heq;
      driveSample(9'd256, 1'b0, lat, b, a, r, alR, alA, rdy, heq);
      total++;
      if (lat !== 3 || {b, a, r} !== 3'b010) begin
         bad++; $display("[TB] FAIL extreme_256: got lat=%0d flags=%b want lat=3 flags=010", lat, {b, a, r});
      end
      total++;
      if (heq !== 1'b0) begin
         bad++; $display("[TB] FAIL extreme_256_early_decide: high eq after edge 1 got %b want 0", heq);
      end
      driveSample(9'd0, 1'b0, lat, b, a, r, alR, alA, rdy, heq);
      total++;
      if (lat !== 3 || {b, a, r} !== 3'b100) begin
         bad++; $display("[TB] FAIL extreme_0: got lat=%0d flags=%b want lat=3 flags=100", lat, {b, a, r});
      end
      driveSample(9'd80, 1'b0, lat, b, a, r, alR, alA, rdy, heq);
      total++;
      if (alA !== 1'b0) begin
         bad++; $display("[TB] FAIL extreme_alarm: got %b want 0", alA);
      end
   endtask

   task automatic test_alarm_debounce();
      logic [8:0] vals [8] = '{9'd120, 9'd120, 9'd80, 9'd120, 9'd80, 9'd120, 9'd120, 9'd120};
      logic       expAl [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      int lat;
      logic b, a, r, alR, alA, rdy, heq;
      for (int k = 0; k < 8; k++) begin
         driveSample(vals[k], 1'b0, lat, b, a, r, alR, alA, rdy, heq);
         total++;
         if (alA !== expAl[k]) begin
            bad++; $display("[TB] FAIL debounce_step%0d: alarm got %b want %b", k, alA, expAl[k]);
         end
      end
      total++;
      if (alR !== 1'b0) begin
         bad++; $display("[TB] FAIL debounce_alarm_timing: alarm during result got %b want 0", alR);
      end
   endtask

   task automatic test_alarm_clear();
      int lat;
      logic b, a, r, alR, alA, rdy, heq;
      driveSample(9'd120, 1'b1, lat, b, a, r, alR, alA, rdy, heq);
      total++;
      if ({alR, alA} !== 2'b10) begin
         bad++; $display("[TB] FAIL clear_edge: alarm before/after got %b want 10", {alR, alA});
      end
      driveSample(9'd120, 1'b0, lat, b, a, r, alR, alA, rdy, heq);
      total++;
      if (alA !== 1'b0) begin
         bad++; $display("[TB] FAIL clear_count_is_one: alarm after 2nd got %b want 0", alA);
      end
      driveSample(9'd120, 1'b0, lat, b, a, r, alR, alA, rdy, heq);
      total++;
      if (alA !== 1'b1) begin
         bad++; $display("[TB] FAIL clear_rearm: alarm after 3rd got %b want 1", alA);
      end
   endtask

   task automatic test_reset_midcmp();
      int pulses = 0;
      bus.sample       = 9'd120;
      bus.sample_valid = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      total++;
      if ({bus.sample_ready, bus.result_valid, bus.below, bus.above, bus.in_range, bus.alarm} !== 6'b100000) begin
         bad++;
         $display("[TB] FAIL midcmp_reset_outputs: got %b want 100000",
                  {bus.sample_ready, bus.result_valid, bus.below, bus.above, bus.in_range, bus.alarm});
      end
      rst_n = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         @(posedge clk); #1;
         if (bus.result_valid) pulses++;
         if (i == 1) begin
            total++;
            if (bus.sample_ready !== 1'b0) begin
               bad++; $display("[TB] FAIL midcmp_reaccept: ready got %b want 0", bus.sample_ready);
            end
         end
         if (i == 4) begin
            total++;
            if (bus.result_valid !== 1'b1 || bus.above !== 1'b1) begin
               bad++;
               $display("[TB] FAIL midcmp_result: rv/above got %b%b want 11", bus.result_valid, bus.above);
            end
            bus.sample_valid = 1'b0;
         end
      end
      total++;
      if (pulses !== 1 || bus.sample_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL midcmp_single_accept: pulses=%0d ready=%b want pulses=1 ready=1",
                  pulses, bus.sample_ready);
      end
   endtask

   initial begin
      rst_n            = 1'b0;
      bus.sample_valid = 1'b0;
      bus.sample       = '0;
      bus.low_thr      = 9'd60;
      bus.high_thr     = 9'd100;
      bus.alarm_clear  = 1'b0;
      test_reset();
      test_basic();
      test_boundaries();
      test_extremes();
      test_alarm_debounce();
      test_alarm_clear();
      test_reset_midcmp();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vital_threshold_monitor.md
# vital_threshold_monitor

Serial threshold checker for one vital-sign channel. Accepts a sampled reading over a valid/ready handshake and compares it against programmable low and high limits. The comparison runs MSB-first, 3 bits per cycle, with registered less/equal/greater cascade state. It sits directly downstream of the sensor sampler and feeds the alarm/display logic with per-sample range flags and a debounced, sticky alarm.

## Interface
- WIDTH, 9, sample and threshold width; must be a multiple of 3; slice count S = WIDTH/3.
- DEBOUNCE, 3, consecutive out-of-range results required to raise `alarm`; range 1..15.

- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- sample_valid  in  1  upstream offers `sample`.
- sample_ready  out  1  block is idle and can accept.
- sample  in  WIDTH  unsigned reading.
- low_thr  in  WIDTH  unsigned lower limit; captured at accept.
- high_thr  in  WIDTH  unsigned upper limit; captured at accept.
- result_valid  out  1  one-cycle pulse; the flags below are valid in this cycle.
- below  out  1  sample < low_thr.
- above  out  1  sample > high_thr.
- in_range  out  1  !below && !above.
- alarm  out  1  sticky debounced alarm.
- alarm_clear  in  1  single-cycle request to clear `alarm` and the debounce count.

## Operation
- FSM states: IDLE, CMP, DONE. `sample_ready` = (state == IDLE).
- IDLE: on `sample_valid && sample_ready`, capture sample, low_thr and high_thr.
  - Initialise both cascade registers to {lt=0, eq=1, gt=0}.
  - Set slice index to S-1 and go to CMP.
  - `sample_valid` is ignored in CMP and DONE.
- CMP: each cycle, compare slice [3i+2:3i] of sample against the same slice of both thresholds.
  - Low and high comparisons run in two parallel chains.
  - Per chain: if eq=1, load lt/eq/gt from the slice comparison. If eq=0, hold; a decided result is never overwritten.
  - After slice 0, go to DONE.
- DONE: `result_valid` = 1.
  - below = low chain lt.
  - above = high chain gt.
  - in_range = !below && !above.
  - Flags are registered and hold their value until the next DONE. They are qualified only by `result_valid`.
  - Next state is IDLE.
- Equality with a threshold counts as in range.
- If low_thr > high_thr, `below` and `above` may both be 1. That sample is out of range; no error flag is raised.
- Debounce counter is 4 bits, saturating at DEBOUNCE. It updates on the DONE→IDLE edge:
  - out-of-range result: count+1;
  - in-range result: count = 0.
- `alarm` sets on the edge where the count reaches DEBOUNCE, then stays set.
- `alarm_clear` sampled high on any edge: alarm = 0 and count = 0.
  - This takes priority over a same-edge increment. An out-of-range result on that edge leaves count = 1, not 0.

## Timing
- Accept on edge 0: CMP covers edges 1..S; `result_valid` is high in the cycle after edge S.
  - Latency: S cycles from accept to result (3 for WIDTH=9).
  - `sample_ready` is high again after edge S+1.
  - Throughput: one sample per S+2 cycles.
- `alarm` rises one cycle after the `result_valid` of the DEBOUNCE-th consecutive out-of-range result.
- Reset (rst_n low at any edge, including mid-CMP or DONE):
  - state = IDLE; the in-flight sample is dropped with no `result_valid`;
  - result_valid, below, above, in_range, alarm, and the count all go to 0;
  - `sample_ready` = 1 from the first cycle after the reset edge.

## Structure
- Package `vitals_pkg` holds:
  - the FSM state enum;
  - SLICE_W = 3;
  - the cascade struct {lt, eq, gt} and its reset constant CASCADE_EQ.
- One combinational sub-module, `cmp_slice3`. It takes two 3-bit operands plus an incoming cascade and returns the outgoing cascade. It is instantiated twice, once for the low chain and once for the high chain.
- Slice selection uses a shift register or indexed part-select; no variable-width arithmetic.

## Test plan
All scenarios use WIDTH=9, DEBOUNCE=3, low_thr=60, high_thr=100.
- Sample 80 accepted on edge 0 → `result_valid` high after edge 3; in_range=1, below=0, above=0; ready after edge 4.
- Samples 60, 100, 59, 101 in turn → in_range, in_range, below=1, above=1 respectively.
- Sample 256 → above=1, with the high chain decided at the first slice (eq=0 after edge 1). Sample 0 → below=1.
- Samples 120,120,120 → alarm=1 one cycle after the 3rd `result_valid`. Samples 120,120,80,120 → alarm stays 0.
- With alarm set, pulse alarm_clear on the same edge as an out-of-range result's DONE→IDLE → alarm=0, count=1; two further 120 samples → alarm=1.
- rst_n low for one edge during the 2nd CMP cycle → no `result_valid`; all outputs 0; sample_ready=1 next cycle; `sample_valid` held high during CMP is not double-accepted.
